// File: rtl/border_sequence_controller.sv
// ============================================================================
// Module   : border_sequence_controller
// Purpose  : Button-driven border grow/shrink sequencer stepping a 0..3 level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module border_sequence_controller #(
  parameter int STEP_CYCLES = 12500000
) (
  input  logic       clock25mhz,
  input  logic       resetn,
  input  logic       btn_grow,
  input  logic       btn_shrink,
  input  logic       enable,
  output logic [3:0] state,
  output logic       busy,
  output logic       done
);

  localparam int c_TIMER_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [c_TIMER_W-1:0] c_STEP_LAST = c_TIMER_W'(STEP_CYCLES - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_GROW   = 2'd1;
  localparam logic [1:0] c_FULL   = 2'd2;
  localparam logic [1:0] c_SHRINK = 2'd3;

  logic                 r_grow_s1, r_grow_s2, r_grow_hist;
  logic                 r_shrink_s1, r_shrink_s2, r_shrink_hist;
  logic                 r_grow_edge, r_shrink_edge;
  logic [1:0]           r_fsm, w_fsm_next;
  logic [1:0]           r_level, w_level_next;
  logic [c_TIMER_W-1:0] r_timer, w_timer_next;
  logic                 r_busy, w_busy_next;
  logic                 r_done, w_done_next;
  logic                 w_grow_edge, w_shrink_edge;
  logic                 w_req_grow, w_req_shrink, w_step;

  assign w_grow_edge   = r_grow_s2 & ~r_grow_hist;
  assign w_shrink_edge = r_shrink_s2 & ~r_shrink_hist;

  // Edges are registered (and gated by enable) so the FSM sees a request
  // on the third edge after the raw input was first sampled high.
  always_ff @(posedge clock25mhz or negedge resetn) begin
    if (!resetn) begin
      r_grow_s1     <= 1'b0;
      r_grow_s2     <= 1'b0;
      r_grow_hist   <= 1'b0;
      r_shrink_s1   <= 1'b0;
      r_shrink_s2   <= 1'b0;
      r_shrink_hist <= 1'b0;
      r_grow_edge   <= 1'b0;
      r_shrink_edge <= 1'b0;
    end else begin
      r_grow_s1     <= btn_grow;
      r_grow_s2     <= r_grow_s1;
      r_grow_hist   <= r_grow_s2;
      r_shrink_s1   <= btn_shrink;
      r_shrink_s2   <= r_shrink_s1;
      r_shrink_hist <= r_shrink_s2;
      r_grow_edge   <= w_grow_edge & enable;
      r_shrink_edge <= w_shrink_edge & enable;
    end
  end

  assign w_req_grow   = r_grow_edge & ~r_shrink_edge;
  assign w_req_shrink = r_shrink_edge & ~r_grow_edge;
  assign w_step       = (r_timer == c_STEP_LAST);

  always_ff @(posedge clock25mhz or negedge resetn) begin
    if (!resetn) begin
      r_fsm   <= c_IDLE;
      r_level <= 2'd0;
      r_timer <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_next;
      r_level <= w_level_next;
      r_timer <= w_timer_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_fsm_next   = r_fsm;
    w_level_next = r_level;
    w_timer_next = r_timer;
    w_done_next  = 1'b0;
    if (enable) begin
      case (r_fsm)
        c_IDLE: begin
          if (w_req_grow) begin
            w_fsm_next   = c_GROW;
            w_level_next = 2'd1;
            w_timer_next = '0;
          end
        end
        c_GROW: begin
          if (w_req_shrink) begin
            w_fsm_next   = c_SHRINK;
            w_timer_next = '0;
          end else if (w_step) begin
            w_timer_next = '0;
            if (r_level != 2'd3) w_level_next = r_level + 2'd1;
            if (r_level == 2'd2) begin
              w_fsm_next  = c_FULL;
              w_done_next = 1'b1;
            end
          end else begin
            w_timer_next = r_timer + 1'b1;
          end
        end
        c_FULL: begin
          if (w_req_shrink) begin
            w_fsm_next   = c_SHRINK;
            w_level_next = 2'd2;
            w_timer_next = '0;
          end
        end
        default: begin
          if (w_req_grow) begin
            w_fsm_next   = c_GROW;
            w_timer_next = '0;
          end else if (w_step) begin
            w_timer_next = '0;
            if (r_level != 2'd0) w_level_next = r_level - 2'd1;
            if (r_level == 2'd1) begin
              w_fsm_next  = c_IDLE;
              w_done_next = 1'b1;
            end
          end else begin
            w_timer_next = r_timer + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_busy_next = (w_fsm_next == c_GROW) || (w_fsm_next == c_SHRINK);
  end

  assign state = {2'b00, r_level};
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_border_sequence_controller.sv
// ============================================================================
// Module   : tb_border_sequence_controller
// Purpose  : Scoreboard bench for border_sequence_controller with a ref model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_border_sequence_controller;

  localparam int c_STEP = 4;

  logic       clock25mhz;
  logic       resetn;
  logic       btn_grow;
  logic       btn_shrink;
  logic       enable;
  logic [3:0] state;
  logic       busy;
  logic       done;

  int checks;
  int failures;
  bit running;

  logic [5:0] exp_q[$];

  // Model: level 0..3 plus a direction (+1 growing, -1 shrinking, 0 resting)
  int m_level, m_dir, m_elapsed;
  bit g_hist[0:4];
  bit s_hist[0:4];
  bit e_hist[0:1];

  border_sequence_controller #(.STEP_CYCLES(c_STEP)) dut (
    .clock25mhz (clock25mhz),
    .resetn     (resetn),
    .btn_grow   (btn_grow),
    .btn_shrink (btn_shrink),
    .enable     (enable),
    .state      (state),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clock25mhz = 1'b0;
    forever #10 clock25mhz = ~clock25mhz;
  end

  task automatic model_step();
    bit gr, sh, m_done;
    m_done = 1'b0;
    if (!resetn) begin
      m_level = 0; m_dir = 0; m_elapsed = 0;
      for (int i = 0; i < 5; i++) begin g_hist[i] = 1'b0; s_hist[i] = 1'b0; end
      e_hist[0] = 1'b0; e_hist[1] = 1'b0;
    end else begin
      for (int i = 4; i > 0; i--) begin g_hist[i] = g_hist[i-1]; s_hist[i] = s_hist[i-1]; end
      g_hist[0] = btn_grow;
      s_hist[0] = btn_shrink;
      e_hist[1] = e_hist[0];
      e_hist[0] = enable;
      gr = g_hist[3] && !g_hist[4] && e_hist[0] && e_hist[1];
      sh = s_hist[3] && !s_hist[4] && e_hist[0] && e_hist[1];
      if (gr && sh) begin gr = 1'b0; sh = 1'b0; end
      if (e_hist[0]) begin
        if (m_dir == 0 && m_level == 0 && gr) begin
          m_level = 1; m_dir = 1; m_elapsed = 0;
        end else if (m_dir == 0 && m_level == 3 && sh) begin
          m_level = 2; m_dir = -1; m_elapsed = 0;
        end else if ((m_dir == 1 && sh) || (m_dir == -1 && gr)) begin
          m_dir = -m_dir; m_elapsed = 0;
        end else if (m_dir != 0) begin
          m_elapsed++;
          if (m_elapsed == c_STEP) begin
            m_elapsed = 0;
            m_level = m_level + m_dir;
            if (m_level == 3 || m_level == 0) begin
              m_dir = 0;
              m_done = 1'b1;
            end
          end
        end
      end
    end
    exp_q.push_back({4'(m_level), (m_dir != 0), m_done});
  endtask

  initial begin
    forever begin
      @(posedge clock25mhz);
      model_step();
    end
  end

  initial begin
    logic [5:0] exp;
    forever begin
      @(negedge clock25mhz);
      if (running) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_empty t=%0t: no expected entry for actual state=%0d busy=%0b done=%0b",
                   $time, state, busy, done);
        end else begin
          exp = exp_q.pop_front();
          if ({state, busy, done} !== exp) begin
            failures++;
            $display("FAIL scoreboard t=%0t: actual state=%0d busy=%0b done=%0b, required state=%0d busy=%0b done=%0b",
                     $time, state, busy, done, exp[5:2], exp[1], exp[0]);
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock25mhz);
  endtask

  task automatic pulse(input bit g, input bit s);
    @(negedge clock25mhz);
    btn_grow = g; btn_shrink = s;
    cycles(2);
    btn_grow = 1'b0; btn_shrink = 1'b0;
  endtask

  task automatic reset_now();
    @(negedge clock25mhz);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: actual state=%0d busy=%0b done=%0b, required state=0 busy=0 done=0",
               state, busy, done);
    end
    @(negedge clock25mhz);
    #2 resetn = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0; running = 1'b1;
    resetn = 1'b0; btn_grow = 1'b0; btn_shrink = 1'b0; enable = 1'b1;
    cycles(3);
    #2 resetn = 1'b1;

    pulse(1, 0); cycles(18);           // single grow to FULL
    pulse(1, 0); cycles(6);            // grow ignored in FULL
    pulse(0, 1); cycles(18);           // full shrink to IDLE
    pulse(0, 1); cycles(6);            // shrink ignored in IDLE
    pulse(1, 1); cycles(8);            // simultaneous edges discarded
    pulse(1, 0); cycles(5);            // reversal at level 2
    pulse(0, 1); cycles(18);
    pulse(1, 0); cycles(6);            // enable freeze at level 2
    enable = 1'b0;
    cycles(1);
    pulse(0, 1); cycles(6);
    enable = 1'b1;
    cycles(12);
    pulse(0, 1); cycles(16);
    pulse(1, 0); cycles(6);            // reset mid-GROW
    reset_now();
    cycles(10);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clock25mhz);
      if ($urandom_range(0, 7) == 0) btn_grow = ~btn_grow;
      if ($urandom_range(0, 7) == 0) btn_shrink = ~btn_shrink;
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 399) == 0) reset_now();
    end
    btn_grow = 1'b0; btn_shrink = 1'b0; enable = 1'b1;
    cycles(20);

    running = 1'b0;
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/border_sequence_controller.md
BORDER_SEQUENCE_CONTROLLER -- requirements
Module: border_sequence_controller

Interface
REQ-001 SHALL provide parameter STEP_CYCLES, default 12500000, meaning clock25mhz cycles between border level steps (legal range 2..2^24-1).
REQ-002 SHALL provide port clock25mhz  input  1  sole clock, all logic on its rising edge.
REQ-003 SHALL provide port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port btn_grow  input  1  raw asynchronous level request to build the border outward.
REQ-005 SHALL provide port btn_shrink  input  1  raw asynchronous level request to retract the border.
REQ-006 SHALL provide port enable  input  1  synchronous run enable; low freezes sequencing.
REQ-007 SHALL provide port state  output  4  border level code for the border renderer, values 0..3 only.
REQ-008 SHALL provide port busy  output  1  high while the border is animating.
REQ-009 SHALL provide port done  output  1  one-cycle pulse when an animation completes.

Function
REQ-010 SHALL pass each of btn_grow and btn_shrink through a 2-flop synchronizer plus a third history flop; edge = sync2 & ~hist.
REQ-011 SHALL register state, busy and done directly from flops; no combinational path from any input to any output.
REQ-012 SHALL implement FSM states IDLE (level 0), GROW, FULL (level 3), SHRINK; state = {2'b00, level[1:0]}.
REQ-013 SHALL hold a step timer of width ceil(log2(STEP_CYCLES)); it counts only in GROW/SHRINK with enable high, otherwise it holds its value.
REQ-014 SHALL, when the timer reaches STEP_CYCLES-1, clear the timer and step level (+1 in GROW, -1 in SHRINK) on that same edge.
REQ-015 SHALL, in IDLE on a grow edge, set level 1, clear the timer and enter GROW on that edge.
REQ-016 SHALL, in GROW, enter FULL and pulse done on the edge where level steps 2->3.
REQ-017 SHALL, in FULL on a shrink edge, set level 2, clear the timer and enter SHRINK.
REQ-018 SHALL, in SHRINK, enter IDLE and pulse done on the edge where level steps 1->0.
REQ-019 SHALL, on a shrink edge in GROW, enter SHRINK, keep the current level and clear the timer; on a grow edge in SHRINK, enter GROW, keep the current level and clear the timer.
REQ-020 SHALL ignore grow edges in FULL or GROW, and shrink edges in IDLE or SHRINK.
REQ-021 SHALL discard both requests when grow and shrink edges occur in the same cycle.
REQ-022 SHALL discard edges while enable is low; FSM, level and timer hold; done is not asserted.
REQ-023 SHALL drive busy = 1 exactly when the FSM is in GROW or SHRINK; done is never high for two consecutive cycles.
REQ-024 SHALL never wrap level: no step above 3 or below 0.
REQ-025 SHALL give a request-to-output latency of 3 edges: raw input high before edge n gives the state update at edge n+3.

Reset
REQ-026 SHALL, on resetn low, asynchronously force FSM IDLE, level 0, timer 0, state 4'd0, busy 0, done 0, and all synchronizer and history flops to 0.
REQ-027 SHALL abort any animation in progress on reset mid-sequence, without emitting done.
REQ-028 SHALL resume operation on the first rising edge after resetn deasserts; a button already held high at release counts as one edge.

Verification (STEP_CYCLES=4, enable=1 unless stated)
REQ-029 SHALL test a single grow: pulse btn_grow -> state 1 at edge+3, 2 four cycles later, 3 four cycles later; done high for exactly 1 cycle; busy 1 then 0.
REQ-030 SHALL test a full shrink: from FULL, pulse btn_shrink -> state 2, 1, 0 at 4-cycle spacing; done pulses once; FSM IDLE.
REQ-031 SHALL test reversal: grow, then shrink request at state 2 -> state holds 2 for 4 cycles, then 1, then 0; exactly one done pulse.
REQ-032 SHALL test simultaneous and illegal requests: both buttons rising on the same edge, shrink in IDLE, and grow in FULL -> state, busy and done unchanged.
REQ-033 SHALL test enable freeze: drop enable at state 2 for 10 cycles with a shrink pulse inside the window -> state stays 2; after enable returns, state 3 follows once the remaining timer count elapses, and shrink is not executed.
REQ-034 SHALL test reset mid-GROW: assert resetn=0 at state 2 -> state 0, busy 0 and done 0 immediately, with no clock edge needed.
